// File: rtl/alu_seq_pkg.sv
// Shared encodings for the multi-byte ALU sequencer: command ops, ALU opcodes,
// shift types and the sequencer state enum.
package alu_seq_pkg;

    // Command opcodes seen on cmd_op
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MOV = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    // 8-bit ALU opcodes
    localparam logic [2:0] ALU_ADC = 3'b010;
    localparam logic [2:0] ALU_SBB = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_MOV = 3'b111;

    // ALU shift types: rotate through carry left / right
    localparam logic [1:0] SH_RCL = 2'b10;
    localparam logic [1:0] SH_RCR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mb_seq.sv
// Multi-byte operation sequencer: runs one command through the 8-bit ALU one
// byte per cycle, chaining carry/borrow/shift bits, then presents the result.
module alu_mb_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 4,
    localparam int unsigned LW = $clog2(MAX_BYTES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [LW-1:0]          cmd_len,
    input  logic [MAX_BYTES*8-1:0] cmd_a,
    input  logic [MAX_BYTES*8-1:0] cmd_b,
    input  logic                   cmd_cin,
    output logic [2:0]             alu_opcode,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_op,
    output logic                   alu_carry_in,
    output logic                   alu_shift_en,
    output logic [1:0]             alu_shift_type,
    input  logic [7:0]             alu_result,
    input  logic                   alu_carry_out,
    input  logic                   alu_zero,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [MAX_BYTES*8-1:0] rsp_data,
    output logic                   rsp_carry,
    output logic                   rsp_zero
);

    localparam int unsigned W = MAX_BYTES * 8;

    state_e        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  res_q, res_d;
    logic          carry_q, carry_d;
    logic          zacc_q, zacc_d;
    logic [W-1:0]  rsp_data_q, rsp_data_d;
    logic          rsp_carry_q, rsp_carry_d;
    logic          rsp_zero_q, rsp_zero_d;

    logic [LW-1:0] pos;
    logic [LW+2:0] bit_base;
    logic          last_byte;

    // SHR walks bytes from the top down so the shifted-out bit enters the next lower byte
    always_comb begin
        pos       = (op_q == OP_SHR) ? (len_q - idx_q) : idx_q;
        bit_base  = {pos, 3'b000};
        last_byte = (idx_q == len_q);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = EXEC;
            EXEC:    if (last_byte) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and ALU drive outputs; ALU inputs are zero outside EXEC
    always_comb begin
        cmd_ready      = (state_q == IDLE);
        rsp_valid      = (state_q == RESP);
        alu_opcode     = 3'b000;
        alu_a          = 8'h00;
        alu_op         = 8'h00;
        alu_carry_in   = 1'b0;
        alu_shift_en   = 1'b0;
        alu_shift_type = 2'b00;
        if (state_q == EXEC) begin
            alu_a        = a_q[bit_base +: 8];
            alu_carry_in = carry_q;
            case (op_q)
                OP_ADD: begin alu_opcode = ALU_ADC; alu_op = b_q[bit_base +: 8]; end
                OP_SUB: begin alu_opcode = ALU_SBB; alu_op = b_q[bit_base +: 8]; end
                OP_AND: begin alu_opcode = ALU_AND; alu_op = b_q[bit_base +: 8]; end
                OP_OR:  begin alu_opcode = ALU_OR;  alu_op = b_q[bit_base +: 8]; end
                OP_XOR: begin alu_opcode = ALU_XOR; alu_op = b_q[bit_base +: 8]; end
                OP_MOV: begin alu_opcode = ALU_MOV; alu_op = b_q[bit_base +: 8]; end
                OP_SHL: begin alu_shift_en = 1'b1; alu_shift_type = SH_RCL; end
                default: begin alu_shift_en = 1'b1; alu_shift_type = SH_RCR; end
            endcase
        end
    end

    // Datapath next-state: latch command in IDLE, accumulate one byte per EXEC cycle
    always_comb begin
        op_d        = op_q;
        len_d       = len_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        carry_d     = carry_q;
        zacc_d      = zacc_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    len_d   = cmd_len;
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    idx_d   = '0;
                    carry_d = cmd_cin;
                    zacc_d  = 1'b1;
                    res_d   = '0;
                end
            end
            EXEC: begin
                res_d[bit_base +: 8] = alu_result;
                carry_d              = alu_carry_out;
                zacc_d               = zacc_q & alu_zero;
                idx_d                = idx_q + 1'b1;
                // Response registers only change once the whole operand is done
                if (last_byte) begin
                    rsp_data_d  = res_d;
                    rsp_carry_d = alu_carry_out;
                    rsp_zero_d  = zacc_d;
                end
            end
            default: ;
        endcase
    end

    // Datapath and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= 3'b000;
            len_q       <= '0;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            zacc_q      <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
        end else begin
            op_q        <= op_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            zacc_q      <= zacc_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    // Response outputs come straight from their registers
    always_comb begin
        rsp_data  = rsp_data_q;
        rsp_carry = rsp_carry_q;
        rsp_zero  = rsp_zero_q;
    end

endmodule

// File: tb/tb_alu_mb_seq.sv
// Bench for alu_mb_seq: behavioural 8-bit ALU beside the DUT, full-width
// reference model feeding a scoreboard queue.
module tb_alu_mb_seq;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_len;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        cmd_cin;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_a;
    logic [7:0]  alu_op;
    logic        alu_carry_in;
    logic        alu_shift_en;
    logic [1:0]  alu_shift_type;
    logic [7:0]  alu_result;
    logic        alu_carry_out;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_zero;

    typedef struct packed {
        logic [31:0] data;
        logic        carry;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_mb_seq #(.MAX_BYTES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_len        (cmd_len),
        .cmd_a          (cmd_a),
        .cmd_b          (cmd_b),
        .cmd_cin        (cmd_cin),
        .alu_opcode     (alu_opcode),
        .alu_a          (alu_a),
        .alu_op         (alu_op),
        .alu_carry_in   (alu_carry_in),
        .alu_shift_en   (alu_shift_en),
        .alu_shift_type (alu_shift_type),
        .alu_result     (alu_result),
        .alu_carry_out  (alu_carry_out),
        .alu_zero       (alu_zero),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_carry      (rsp_carry),
        .rsp_zero       (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8-bit ALU
    logic [8:0] alu_t;
    always_comb begin
        alu_t         = 9'd0;
        alu_result    = 8'h00;
        alu_carry_out = 1'b0;
        if (alu_shift_en) begin
            if (alu_shift_type == 2'b10) begin
                alu_result    = {alu_a[6:0], alu_carry_in};
                alu_carry_out = alu_a[7];
            end else if (alu_shift_type == 2'b11) begin
                alu_result    = {alu_carry_in, alu_a[7:1]};
                alu_carry_out = alu_a[0];
            end
        end else begin
            case (alu_opcode)
                3'b010: begin
                    alu_t = {1'b0, alu_a} + {1'b0, alu_op} + {8'd0, alu_carry_in};
                    alu_result = alu_t[7:0]; alu_carry_out = alu_t[8];
                end
                3'b011: begin
                    alu_t = {1'b0, alu_a} - {1'b0, alu_op} - {8'd0, alu_carry_in};
                    alu_result = alu_t[7:0]; alu_carry_out = alu_t[8];
                end
                3'b100: alu_result = alu_a & alu_op;
                3'b101: alu_result = alu_a | alu_op;
                3'b110: alu_result = alu_a ^ alu_op;
                3'b111: begin alu_result = alu_op; alu_carry_out = alu_carry_in; end
                default: alu_result = alu_a;
            endcase
        end
        alu_zero = (alu_result == 8'h00);
    end

    // Whole-operand reference model
    function automatic exp_t ref_model(input logic [2:0] op, input logic [1:0] len,
                                       input logic [31:0] a, input logic [31:0] b,
                                       input logic cin);
        int          w;
        logic [63:0] m, aa, bb, s, c;
        exp_t        r;
        w  = 8 * (int'(len) + 1);
        m  = (64'd1 << w) - 64'd1;
        aa = {32'd0, a} & m;
        bb = {32'd0, b} & m;
        c  = {63'd0, cin};
        r.carry = 1'b0;
        case (op)
            3'd0: begin s = aa + bb + c; r.data = s[31:0] & m[31:0]; r.carry = s[w]; end
            3'd1: begin s = aa - bb - c; r.data = s[31:0] & m[31:0]; r.carry = (aa < bb + c); end
            3'd2: r.data = aa[31:0] & bb[31:0];
            3'd3: r.data = aa[31:0] | bb[31:0];
            3'd4: r.data = aa[31:0] ^ bb[31:0];
            3'd5: begin r.data = bb[31:0]; r.carry = cin; end
            3'd6: begin s = (aa << 1) | c; r.data = s[31:0] & m[31:0]; r.carry = aa[w-1]; end
            default: begin s = (aa >> 1) | (c << (w - 1)); r.data = s[31:0]; r.carry = aa[0]; end
        endcase
        r.zero = (r.data == 32'd0);
        return r;
    endfunction

    // Present a command, wait (bounded) for acceptance, push its expected result
    task automatic send_cmd(input logic [2:0] op, input logic [1:0] len, input logic [31:0] a,
                            input logic [31:0] b, input logic cin);
        int n;
        @(negedge clk);
        cmd_op = op; cmd_len = len; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout cmd_ready=%0b required 1", cmd_ready);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            sb.push_back(ref_model(op, len, a, b, cin));
            #1;
            // Scramble inputs after acceptance; the DUT must not notice
            cmd_valid = 1'b0;
            cmd_a = $urandom; cmd_b = $urandom; cmd_cin = 1'($urandom);
            cmd_op = 3'($urandom); cmd_len = 2'($urandom);
        end
    endtask

    // Wait (bounded) for rsp_valid; cyc counts falling edges after acceptance
    task automatic wait_rsp(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rsp_valid && cyc < 100);
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout rsp_valid=%0b required 1", rsp_valid);
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (cmd_ready !== 1'b1) begin errors++;
            $display("FAIL reset_cmd_ready got %0b want 1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++;
            $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
        checks++; if ({rsp_data, rsp_carry, rsp_zero} !== 34'd0) begin errors++;
            $display("FAIL reset_rsp got %h/%0b/%0b want 0", rsp_data, rsp_carry, rsp_zero); end
        checks++;
        if ({alu_opcode, alu_a, alu_op, alu_carry_in, alu_shift_en, alu_shift_type} !== 23'd0)
        begin errors++;
            $display("FAIL reset_alu_drive got %h want 0",
                     {alu_opcode, alu_a, alu_op, alu_carry_in, alu_shift_en, alu_shift_type});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int   cyc;
        exp_t e;
        send_cmd(3'd0, 2'd1, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        wait_rsp(cyc);
        e = sb.pop_front();
        checks++; if (cyc !== 3) begin errors++;
            $display("FAIL add_latency got %0d want 3", cyc); end
        checks++; if (rsp_data !== e.data || e.data !== 32'h0000_0100) begin errors++;
            $display("FAIL add_data got %h want %h", rsp_data, e.data); end
        checks++; if (rsp_carry !== e.carry) begin errors++;
            $display("FAIL add_carry got %0b want %0b", rsp_carry, e.carry); end
        checks++; if (rsp_zero !== e.zero) begin errors++;
            $display("FAIL add_zero got %0b want %0b", rsp_zero, e.zero); end
        consume();
    endtask

    task automatic test_sub();
        int   cyc;
        exp_t e;
        send_cmd(3'd1, 2'd3, 32'h0000_0000, 32'h0000_0001, 1'b0);
        @(negedge clk);
        checks++; if ({alu_opcode, alu_a, alu_op} !== {3'b011, 8'h00, 8'h01}) begin errors++;
            $display("FAIL sub_alu_drive got %h want %h", {alu_opcode, alu_a, alu_op},
                     {3'b011, 8'h00, 8'h01}); end
        wait_rsp(cyc);
        e = sb.pop_front();
        checks++; if (rsp_data !== e.data) begin errors++;
            $display("FAIL sub_data got %h want %h", rsp_data, e.data); end
        checks++; if (rsp_carry !== 1'b1) begin errors++;
            $display("FAIL sub_borrow got %0b want 1", rsp_carry); end
        checks++; if (rsp_zero !== 1'b0) begin errors++;
            $display("FAIL sub_zero got %0b want 0", rsp_zero); end
        consume();
    endtask

    task automatic test_shift();
        int   cyc;
        exp_t e;
        send_cmd(3'd7, 2'd1, 32'h0000_0101, 32'h0, 1'b1);
        wait_rsp(cyc);
        e = sb.pop_front();
        checks++; if ({rsp_data, rsp_carry} !== {32'h0000_8080, 1'b1}) begin errors++;
            $display("FAIL shr_result got %h/%0b want 00008080/1", rsp_data, rsp_carry); end
        checks++; if (rsp_zero !== e.zero) begin errors++;
            $display("FAIL shr_zero got %0b want %0b", rsp_zero, e.zero); end
        consume();

        send_cmd(3'd6, 2'd1, 32'h0000_8001, 32'h0, 1'b0);
        wait_rsp(cyc);
        e = sb.pop_front();
        checks++; if ({rsp_data, rsp_carry} !== {e.data, e.carry} || e.data !== 32'h2) begin
            errors++;
            $display("FAIL shl_result got %h/%0b want %h/%0b", rsp_data, rsp_carry,
                     e.data, e.carry); end
        consume();

        // SHR must present the high byte to the ALU first
        send_cmd(3'd7, 2'd1, 32'h0000_1234, 32'h0, 1'b0);
        @(negedge clk);
        checks++;
        if ({alu_shift_en, alu_shift_type, alu_a} !== {1'b1, 2'b11, 8'h12}) begin errors++;
            $display("FAIL shr_order_byte1 got %h want %h", {alu_shift_en, alu_shift_type, alu_a},
                     {1'b1, 2'b11, 8'h12}); end
        @(negedge clk);
        checks++; if ({alu_a, alu_carry_in} !== {8'h34, 1'b0}) begin errors++;
            $display("FAIL shr_order_byte0 got %h/%0b want 34/0", alu_a, alu_carry_in); end
        wait_rsp(cyc);
        e = sb.pop_front();
        checks++; if ({rsp_data, rsp_carry} !== {e.data, e.carry}) begin errors++;
            $display("FAIL shr2_result got %h/%0b want %h/%0b", rsp_data, rsp_carry,
                     e.data, e.carry); end
        consume();
    endtask

    task automatic test_logic_mov();
        int   cyc;
        exp_t e;
        send_cmd(3'd4, 2'd3, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1);
        wait_rsp(cyc);
        e = sb.pop_front();
        checks++; if (rsp_data !== 32'd0) begin errors++;
            $display("FAIL xor_data got %h want 00000000", rsp_data); end
        checks++; if ({rsp_zero, rsp_carry} !== 2'b10) begin errors++;
            $display("FAIL xor_flags got z%0b c%0b want z1 c0", rsp_zero, rsp_carry); end
        consume();

        send_cmd(3'd0, 2'd0, 32'h0000_0042, 32'h0000_0042, 1'b0);
        wait_rsp(cyc);
        e = sb.pop_front();
        checks++; if (cyc !== 2) begin errors++;
            $display("FAIL len0_latency got %0d want 2", cyc); end
        consume();

        send_cmd(3'd5, 2'd0, 32'hFFFF_FF00, 32'h0000_0042, 1'b1);
        wait_rsp(cyc);
        e = sb.pop_front();
        checks++; if ({rsp_data, rsp_carry, rsp_zero} !== {e.data, e.carry, e.zero}) begin
            errors++;
            $display("FAIL mov_result got %h/%0b/%0b want %h/%0b/%0b", rsp_data, rsp_carry,
                     rsp_zero, e.data, e.carry, e.zero); end
        consume();
    endtask

    task automatic test_random();
        int   cyc;
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            send_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                     1'($urandom));
            wait_rsp(cyc);
            e = sb.pop_front();
            checks++;
            if ({rsp_data, rsp_carry, rsp_zero} !== {e.data, e.carry, e.zero}) begin errors++;
                $display("FAIL random_%0d got %h/%0b/%0b want %h/%0b/%0b", i, rsp_data,
                         rsp_carry, rsp_zero, e.data, e.carry, e.zero); end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        exp_t e;
        send_cmd(3'd0, 2'd1, 32'h0000_1234, 32'h0000_1111, 1'b0);
        wait_rsp(cyc);
        e = sb.pop_front();
        // New command waits while the response is held
        cmd_op = 3'd4; cmd_len = 2'd3; cmd_a = 32'hF0F0_F0F0; cmd_b = 32'h0F0F_0F0F;
        cmd_cin = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_data, rsp_carry, rsp_zero} !== {1'b1, e.data, e.carry, e.zero})
            begin errors++;
                $display("FAIL hold_rsp_%0d got %0b/%h want 1/%h", i, rsp_valid, rsp_data,
                         e.data); end
            checks++; if (cmd_ready !== 1'b0) begin errors++;
                $display("FAIL hold_cmd_ready_%0d got %0b want 0", i, cmd_ready); end
        end
        checks++; if ({alu_opcode, alu_a, alu_op, alu_shift_en} !== 20'd0) begin errors++;
            $display("FAIL resp_alu_idle got %h want 0", {alu_opcode, alu_a, alu_op}); end
        consume();
        @(negedge clk);
        checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin errors++;
            $display("FAIL after_consume ready%0b valid%0b want ready1 valid0", cmd_ready,
                     rsp_valid); end
        @(posedge clk);
        sb.push_back(ref_model(3'd4, 2'd3, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0));
        #1 cmd_valid = 1'b0;
        wait_rsp(cyc);
        e = sb.pop_front();
        checks++; if (cyc !== 5) begin errors++;
            $display("FAIL b2b_latency got %0d want 5", cyc); end
        checks++; if ({rsp_data, rsp_carry, rsp_zero} !== {e.data, e.carry, e.zero}) begin
            errors++;
            $display("FAIL b2b_result got %h/%0b/%0b want %h/%0b/%0b", rsp_data, rsp_carry,
                     rsp_zero, e.data, e.carry, e.zero); end
        consume();
    endtask

    task automatic test_reset_mid();
        int seen;
        send_cmd(3'd0, 2'd3, 32'h1111_1111, 32'h2222_2222, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        checks++; if ({rsp_valid, rsp_data, rsp_carry, rsp_zero} !== 35'd0) begin errors++;
            $display("FAIL midreset_rsp got %0b/%h want 0/00000000", rsp_valid, rsp_data); end
        checks++;
        if ({alu_opcode, alu_a, alu_op, alu_carry_in, alu_shift_en, alu_shift_type} !== 23'd0)
        begin errors++;
            $display("FAIL midreset_alu got %h want 0", {alu_opcode, alu_a, alu_op}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++;
            $display("FAIL midreset_cmd_ready got %0b want 1", cmd_ready); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++;
            $display("FAIL midreset_no_rsp got %0d valid cycles want 0", seen); end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_len = 2'd0; cmd_a = 32'd0; cmd_b = 32'd0;
        cmd_cin = 1'b0; rsp_ready = 1'b0; rst_n = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_shift();
        test_logic_mov();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mb_seq.md
Name: alu_mb_seq

Overview:
- Multi-byte operation sequencer for the 8-bit ALU.
- Accepts one command on operands up to MAX_BYTES bytes wide. Drives the ALU one byte per cycle, chaining carry/borrow and shift carry between bytes. Returns the assembled result with final carry and zero flags.
- Sits between the control unit and the ALU, so 16/32-bit arithmetic, logic and rotate-through-carry need no software loops.

Parameters:
- MAX_BYTES, 4, max operand width in bytes; power of two, 2..8. Data ports are MAX_BYTES*8 bits wide.
- LW, $clog2(MAX_BYTES), width of cmd_len (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  sequencer idle and can accept.
- cmd_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV, 6 SHL, 7 SHR.
- cmd_len  in  LW  byte count minus 1.
- cmd_a  in  MAX_BYTES*8  operand A.
- cmd_b  in  MAX_BYTES*8  operand B (ignored for SHL/SHR).
- cmd_cin  in  1  initial carry/borrow/shift-in bit.
- alu_opcode  out  3  to ALU opcode.
- alu_a  out  8  to ALU A.
- alu_op  out  8  to ALU op.
- alu_carry_in  out  1  to ALU carry_in.
- alu_shift_en  out  1  to ALU shift_en.
- alu_shift_type  out  2  to ALU shift_type.
- alu_result  in  8  from ALU result.
- alu_carry_out  in  1  from ALU carry_out.
- alu_zero  in  1  from ALU zero.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  MAX_BYTES*8  result; bytes above cmd_len are 0.
- rsp_carry  out  1  final carry / borrow / shifted-out bit.
- rsp_zero  out  1  1 iff all processed result bytes are 0.

Behaviour:
- Reset: state IDLE. rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_zero=0, cmd_ready=1. ALU drive outputs are all 0. Reset asserted mid-EXEC or mid-RESP aborts the operation; nothing is reported.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch the command, set carry register to cmd_cin, zero accumulator to 1, result register to 0, then go to EXEC.
  - EXEC: one byte per cycle, index k from 0 to cmd_len. After the last byte, go to RESP.
  - RESP: rsp_valid=1, outputs held stable. On rsp_ready, go to IDLE.
- cmd_ready=0 outside IDLE. A command is never accepted in the same cycle a response is consumed.
- Latency: accept at cycle T; bytes processed T+1..T+cmd_len+1; rsp_valid from T+cmd_len+2.
- ALU drive is combinational from registered state. The ALU is combinational, so each byte result is captured at the end of its EXEC cycle:
  - result byte register <= alu_result
  - carry register <= alu_carry_out
  - zero accumulator &= alu_zero
- Op mapping (in EXEC), with alu_carry_in = carry register for every row:
  - ADD: opcode 010 (ADC); byte order LSB to MSB.
  - SUB: opcode 011 (SBB); LSB to MSB. Carry = borrow, 1 on underflow.
  - AND: opcode 100; LSB to MSB.
  - OR: opcode 101; LSB to MSB.
  - XOR: opcode 110; LSB to MSB.
  - MOV: opcode 111; LSB to MSB.
  - SHL: shift_en=1, shift_type 10; LSB to MSB.
  - SHR: shift_en=1, shift_type 11; MSB (byte cmd_len) down to byte 0.
- Final-carry consequences: logic ops leave carry 0; MOV passes cmd_cin through.
- Outside EXEC, all ALU drive outputs are 0.
- cmd_len=0 gives a single-byte op with 2-cycle latency.
- Response registers are written only in EXEC. rsp_* holds indefinitely under rsp_ready=0. Changes to cmd_* after acceptance have no effect.

Decomposition:
- Package alu_seq_pkg holds:
  - cmd_op encodings (OP_ADD..OP_SHR)
  - ALU opcode constants (ALU_ADC=3'b010, ALU_SBB=3'b011, ALU_AND, ALU_OR, ALU_XOR, ALU_MOV)
  - shift_type constants (SH_RCL=2'b10, SH_RCR=2'b11)
  - state enum (IDLE, EXEC, RESP)
- No sub-module. The ALU is instantiated beside this block by the parent and by the bench.

Test Plan:
- ADD, len=1, a=0x00FF, b=0x0001, cin=0 -> rsp_data=0x0100, carry=0, zero=0; rsp_valid 3 cycles after accept.
- SUB, len=3, a=0x00000000, b=0x00000001, cin=0 -> rsp_data=0xFFFFFFFF, carry=1, zero=0.
- SHR, len=1, a=0x0101, cin=1 -> 0x8080, carry=1. SHL, len=1, a=0x8001, cin=0 -> 0x0002, carry=1; check MSB-first ALU byte order for SHR.
- XOR, len=3, a=b=0xA5A5A5A5 -> rsp_data=0, zero=1, carry=0. MOV, len=0, b=0x00000042, cin=1 -> rsp_data=0x42, carry=1.
- Backpressure: hold rsp_ready=0 for 5 cycles while cmd_valid=1 with new operands -> rsp_* stable, cmd_ready=0, second command accepted only the cycle after rsp_ready.
- rst_n pulsed low in the 2nd EXEC cycle of a 4-byte ADD -> all outputs 0 immediately, cmd_ready=1 after release, no rsp_valid.
